ysyx_22050039_ifu: RTL

Instruction fetch unit for the multi-cycle NPC core; sits directly upstream of the decode/execute path and feeds it (pc, inst) pairs.
- Owns the PC register and issues one instruction-memory request at a time over a valid/ready request and valid response interface.
- Holds each fetched instruction until downstream accepts it.
- Accepts a redirect (branch/jump target) from later stages at any time and discards stale fetches.

---
 rtl/ysyx_22050039_pkg.sv | 16 +
 rtl/ysyx_22050039_ifu.sv | 115 +++++++++++
 2 files changed

// File: rtl/ysyx_22050039_pkg.sv
// Shared types and constants for the ysyx_22050039 NPC core.
// Imported by the instruction fetch unit.
package ysyx_22050039_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } ifu_state_e;

  localparam logic [63:0] RESET_PC_DEFAULT = 64'h8000_0000;
  localparam int          ILEN             = 32;
  localparam int          PC_STEP          = 4;

endpackage

// File: rtl/ysyx_22050039_ifu.sv
// Instruction fetch unit: owns the PC, issues one imem request at a time,
// holds the fetched (pc, inst, fault) until downstream accepts it.
module ysyx_22050039_ifu
  import ysyx_22050039_pkg::*;
#(
  parameter int               XLEN     = 64,
  parameter logic [XLEN-1:0]  RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN-1:0]   imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [ILEN-1:0]   imem_resp_data,
  input  logic              imem_resp_err,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [ILEN-1:0]   out_inst,
  output logic              out_fault
);

  ifu_state_e      state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pend_pc;
  logic            pend;
  logic            drop;
  logic [XLEN-1:0] target;

  assign target         = {redirect_pc[XLEN-1:2], 2'b00};
  assign imem_req_valid = (state == REQ);
  assign imem_req_addr  = pc;

  // NOTE: all state here is sequential, so every update uses non-blocking
  // assignment; blocking would let later statements see half-updated state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      pend_pc   <= RESET_PC;
      pend      <= 1'b0;
      drop      <= 1'b0;
      out_valid <= 1'b0;
      out_pc    <= RESET_PC;
      out_inst  <= '0;
      out_fault <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          state <= REQ;
          if (redirect_valid) pc <= target;
        end

        REQ: begin
          if (imem_req_ready) begin
            state <= WAIT;
            pend  <= 1'b0;
            // The accepted request went to the old pc; its response is stale.
            if (redirect_valid) begin
              drop <= 1'b1;
              pc   <= target;
            end else if (pend) begin
              drop <= 1'b1;
              pc   <= pend_pc;
            end
          end else if (redirect_valid) begin
            // Address must hold while the request is pending; park the target.
            pend    <= 1'b1;
            pend_pc <= target;
          end
        end

        WAIT: begin
          if (imem_resp_valid) begin
            if (redirect_valid) begin
              pc    <= target;
              drop  <= 1'b0;
              state <= REQ;
            end else if (drop) begin
              drop  <= 1'b0;
              state <= REQ;
            end else begin
              out_valid <= 1'b1;
              out_pc    <= pc;
              out_inst  <= imem_resp_data;
              out_fault <= imem_resp_err;
              pc        <= pc + XLEN'(PC_STEP);
              state     <= HOLD;
            end
          end else if (redirect_valid) begin
            pc   <= target;
            drop <= 1'b1;
          end
        end

        HOLD: begin
          if (redirect_valid) begin
            out_valid <= 1'b0;
            pc        <= target;
            state     <= REQ;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= REQ;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
